vga_timing: RTL
===============

# vga_timing

SVGA 800x600@60 Hz raster timing generator for the pixel-clock domain. It sits directly upstream of the game drawing pipeline: it produces the pixel counters, sync pulses and blanking flags that the draw stages consume and delay. Its `vsync` and `hsync` ultimately reach the board pins and the frame-capture model as `vs` and `hs`. The total raster is 1056x628 pixels.

## Interface
Parameters:
- `H_VISIBLE`, default 800: active pixels per line.
- `H_FRONT`, default 40: horizontal front porch, in pixels.
- `H_SYNC`, default 128: hsync width, in pixels.
- `H_BACK`, default 88: horizontal back porch, in pixels.
- `V_VISIBLE`, default 600: active lines per frame.
- `V_FRONT`, default 1: vertical front porch, in lines.
- `V_SYNC`, default 4: vsync width, in lines.
- `V_BACK`, default 23: vertical back porch, in lines.

Ports (one clock; reset is synchronous and active-low):
- `pclk`  in  1  pixel clock, 40 MHz. All logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `hcount`  out  11  horizontal pixel index, 0..H_TOTAL-1.
- `vcount`  out  11  line index, 0..V_TOTAL-1.
- `hsync`  out  1  horizontal sync, active-high.
- `vsync`  out  1  vertical sync, active-high.
- `hblnk`  out  1  1 outside the horizontal visible region.
- `vblnk`  out  1  1 outside the vertical visible region.
- `frame_start`  out  1  one-cycle pulse, high while at pixel (0,0).

## Operation
- Derived constants:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK = 1056.
  - V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK = 628.
- Horizontal counter:
  - Increments every cycle.
  - When hcount == H_TOTAL-1, it wraps to 0 on the next edge and vcount advances.
- Vertical counter:
  - Increments only on a horizontal wrap.
  - When vcount == V_TOTAL-1 and hcount wraps, vcount also wraps to 0.
- All outputs are registered and coherent. Each cycle, the flags describe exactly the pixel given by the current hcount/vcount:
  - hblnk = (hcount >= H_VISIBLE), i.e. 800..1055.
  - hsync = (H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC), i.e. 840..967.
  - vblnk = (vcount >= V_VISIBLE), i.e. 600..627.
  - vsync = (V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC), i.e. 601..604.
  - frame_start = (hcount==0 && vcount==0), except in the reset state.
- Flag implementation: compute each flag from the next-state counter values and register it alongside the counters. There is no one-cycle skew between counters and flags.
- vsync timing: vsync changes only when hcount transitions to 0, never mid-line.
- Arithmetic: counters are 11-bit unsigned. No value ≥ H_TOTAL (or ≥ V_TOTAL) may ever appear on the outputs.
- Reset (rst_n sampled low at a rising edge): on that same edge, every output is forced to its reset value.
  - hcount=0, vcount=0.
  - hsync=0, vsync=0, hblnk=0, vblnk=0.
  - frame_start=0.
  - This applies at any point in the frame, including mid-sync.
- First edge after release: with rst_n high, the first edge yields hcount=1, vcount=0. No frame_start pulse is emitted for the reset frame.
- No other state: there is no FSM beyond the two counters. The block has no handshake, no stall, and no dependence on downstream stages.

## Timing
- Latency from reset release: 0. Counting starts on the first edge with rst_n=1.
- Line period: 1056 cycles = 26.4 µs at 40 MHz.
- Frame period: 663 168 cycles = 16.579 ms.
- Successive frame_start pulses, and successive vsync rising edges, are exactly 663 168 cycles apart.
- hsync: high for exactly 128 consecutive cycles per line, for every line including vertical blanking.
- vsync: high for exactly 4×1056 = 4224 consecutive cycles, from (0,601) through (1055,604).
- Downstream stages delaying these signals must delay all seven outputs by the same amount.

## Test plan
- Reset: hold rst_n=0 for 10 cycles.
  - During and immediately after: all outputs are 0.
  - First edge with rst_n=1: hcount=1, vcount=0.
- Line scan: hblnk, hsync and line wrap.
  - hblnk rises at hcount=800.
  - hsync is high for hcount 840..967, low at 968.
  - After hcount=1055, the next cycle shows hcount=0 and vcount incremented.
- Frame scan: vblnk, vsync and frame wrap.
  - vblnk is high for vcount 600..627.
  - vsync rises at (0,601) and falls at (0,605).
  - (1055,627) is followed by (0,0) with frame_start=1 for exactly 1 cycle.
- Period check: measure between consecutive vsync negedges.
  - Separation must be exactly 663 168 cycles, i.e. 16 579 200 ns at a 25 ns period.
- Mid-operation reset: pull rst_n low for 1 cycle while vcount=602 and hsync=1.
  - Next cycle: all outputs are 0.
  - Counting restarts from hcount=1; the next frame_start arrives 663 167 cycles after release.
- Invariant check, run for 3 full frames:
  - hcount < 1056 and vcount < 628 at all times.
  - Flags always match the decode formulas for the current counters.

Source files
------------

// File: rtl/vga_timing.sv
// SVGA raster timing generator: free-running pixel/line counters with
// sync and blanking flags registered alongside the counters.
`timescale 1ns/1ps
module vga_timing #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23
) (
    input  logic        pclk,
    input  logic        rst_n,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END   = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END   = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_hblnk;
    logic        r_vblnk;
    logic        r_frame_start;

    logic [10:0] w_hcount_next;
    logic [10:0] w_vcount_next;
    logic        w_hsync_next;
    logic        w_vsync_next;
    logic        w_hblnk_next;
    logic        w_vblnk_next;
    logic        w_frame_start_next;

    // Next-state counters; the line counter only moves on a horizontal wrap.
    always_comb begin
        w_hcount_next = r_hcount + 11'd1;
        w_vcount_next = r_vcount;
        if (r_hcount == H_LAST) begin
            w_hcount_next = 11'd0;
            if (r_vcount == V_LAST) begin
                w_vcount_next = 11'd0;
            end else begin
                w_vcount_next = r_vcount + 11'd1;
            end
        end
    end

    // Flags decode the next counter values so they land in the same cycle
    // as the pixel they describe.
    always_comb begin
        w_hblnk_next       = (w_hcount_next >= H_VIS_END);
        w_hsync_next       = (w_hcount_next >= H_SYNC_BEG) && (w_hcount_next < H_SYNC_END);
        w_vblnk_next       = (w_vcount_next >= V_VIS_END);
        w_vsync_next       = (w_vcount_next >= V_SYNC_BEG) && (w_vcount_next < V_SYNC_END);
        w_frame_start_next = (w_hcount_next == 11'd0) && (w_vcount_next == 11'd0);
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_hcount      <= 11'd0;
            r_vcount      <= 11'd0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcount      <= w_hcount_next;
            r_vcount      <= w_vcount_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_hblnk       <= w_hblnk_next;
            r_vblnk       <= w_vblnk_next;
            r_frame_start <= w_frame_start_next;
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblnk       = r_hblnk;
    assign vblnk       = r_vblnk;
    assign frame_start = r_frame_start;

endmodule
